// File: rtl/vga_pkg.sv
// Shared types for the VGA span plotter.
// Command field offsets, FSM state and the queued command bundle.
package vga_pkg;

  localparam int CMD_SPAN_BIT = 31;
  localparam int CMD_Y_LSB    = 24;
  localparam int CMD_X_LSB    = 16;
  localparam int CMD_LEN_LSB  = 8;

  typedef enum logic {
    IDLE,
    DRAW
  } plot_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] len;
    logic [7:0] colour;
  } plot_cmd_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Plot command FIFO: DEPTH entries of plot_cmd_t.
// Head is shown combinationally; push ignored when full.
module vga_cmd_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  plot_cmd_t push_data,
  input  logic      pop,
  output plot_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  plot_cmd_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_span_plotter.sv
// Buffered pixel/span plot engine, one pixel per clock, clipped.
// Optional dropped-pixel counter: VGA_PLOT_CLIP_COUNT_EN.
module vga_span_plotter
  import vga_pkg::*;
#(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         data_in,
  output logic                ready,
  output logic                busy,
  output logic                vga_plot,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour
`ifdef VGA_PLOT_CLIP_COUNT_EN
  ,
  output logic [15:0]         clip_count
`endif
);

  localparam logic [7:0] X_LIM  = 8'(SCREEN_W);
  localparam logic [7:0] X_EDGE = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LIM  = 7'(SCREEN_H);

  plot_state_t state;
  plot_state_t state_nxt;
  plot_cmd_t   cmd_in;
  plot_cmd_t   head;
  logic        full;
  logic        empty;
  logic        pop;

  logic [7:0]  x_r;
  logic [6:0]  y_r;
  logic [7:0]  rem_r;
  logic [7:0]  col_r;

  logic        in_bounds;
  logic        at_edge;
  logic        last_beat;
  logic        unused_bits;

  always_comb begin
    cmd_in        = '0;
    cmd_in.x      = 8'(data_in[CMD_X_LSB +: X_W]);
    cmd_in.y      = 7'(data_in[CMD_Y_LSB +: Y_W]);
    cmd_in.colour = 8'(data_in[0 +: COLOUR_W]);
    cmd_in.len    = data_in[CMD_SPAN_BIT]
                  ? data_in[CMD_LEN_LSB +: 8]
                  : 8'd0;
  end

  vga_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (start),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign in_bounds = (x_r < X_LIM) && (y_r < Y_LIM);
  assign at_edge   = (x_r == X_EDGE);
  assign last_beat = (rem_r == 8'd0) || !in_bounds || at_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Last beat refills straight from the FIFO so spans abut.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (last_beat) begin
          pop = !empty;
          if (empty) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      rem_r <= '0;
      col_r <= '0;
    end else if (pop) begin
      x_r   <= head.x;
      y_r   <= head.y;
      rem_r <= head.len;
      col_r <= head.colour;
    end else if (state == DRAW && !last_beat) begin
      x_r   <= x_r + 8'd1;
      rem_r <= rem_r - 8'd1;
    end
  end

  always_comb begin
    ready      = !full;
    busy       = !empty || (state == DRAW);
    vga_plot   = (state == DRAW) && in_bounds;
    vga_x      = x_r[X_W-1:0];
    vga_y      = y_r[Y_W-1:0];
    vga_colour = col_r[COLOUR_W-1:0];
  end

  assign unused_bits = ^{data_in, col_r};

`ifdef VGA_PLOT_CLIP_COUNT_EN
  logic [8:0]  clip_add;
  logic [16:0] clip_sum;

  // Off-screen drops the current pixel too; edge drops only the rest.
  always_comb begin
    clip_add = 9'd0;
    if (!in_bounds)   clip_add = {1'b0, rem_r} + 9'd1;
    else if (at_edge) clip_add = {1'b0, rem_r};
  end

  assign clip_sum = {1'b0, clip_count} + 17'(clip_add);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (state == DRAW && last_beat) begin
      clip_count <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_vga_span_plotter.sv
// Scoreboard bench for vga_span_plotter.
// Clip counter is checked when VGA_PLOT_CLIP_COUNT_EN is defined.
module tb_vga_span_plotter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        ready;
  logic        busy;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
`ifdef VGA_PLOT_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  vga_span_plotter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .ready      (ready),
    .busy       (busy),
    .vga_plot   (vga_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour)
`ifdef VGA_PLOT_CLIP_COUNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } beat_t;

  beat_t exp_q[$];
  int    exp_clip = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    mon_cnt = 0;
  int    mon_first = 0;
  int    mon_last = 0;

  always @(negedge clk) begin
    if (!rst && vga_plot) begin
      beat_t e;
      if (mon_cnt == 0) mon_first = cyc;
      mon_last = cyc;
      mon_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat got x=%0d y=%0d c=%0d want none",
                 vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          n_fail++;
          $display("FAIL beat got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  // Reference: clip at the right/bottom edge, no wrap.
  task automatic expand(input logic [31:0] c);
    int x, y, len, n;
    beat_t b;
    x   = int'(c[23:16]);
    y   = int'(c[30:24]);
    len = c[31] ? int'(c[15:8]) : 0;
    n   = 0;
    for (int i = 0; i <= len; i++) begin
      if (x + i >= 160 || y >= 120) break;
      b.x = 8'(x + i);
      b.y = 7'(y);
      b.c = c[2:0];
      exp_q.push_back(b);
      n++;
    end
    exp_clip += len + 1 - n;
  endtask

  task automatic send(input logic [31:0] c, input bit model,
                      output int n);
    @(negedge clk);
    start   = 1'b1;
    data_in = c;
    if (model) expand(c);
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = cyc;
  endtask

  task automatic wait_idle(input int budget, output int t,
                           output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic burst(input logic [31:0] span,
                       output bit rdy [5], output int n0);
    logic [31:0] c;
    @(negedge clk);
    start   = 1'b1;
    data_in = span;
    expand(span);
    @(posedge clk);
    #1;
    n0 = cyc;
    for (int i = 0; i < 5; i++) begin
      c = {1'b0, 7'(60 + i), 8'(100 + i), 8'd0, 8'(i + 1)};
      @(negedge clk);
      rdy[i]  = ready;
      start   = 1'b1;
      data_in = c;
      if (i < 4) expand(c);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic check_clip(input string nm);
`ifdef VGA_PLOT_CLIP_COUNT_EN
    n_tests++;
    if (clip_count !== 16'(exp_clip)) begin
      n_fail++;
      $display("FAIL %s clip_count got %0d want %0d",
               nm, clip_count, exp_clip);
    end
`endif
  endtask

  task automatic check_done(input string nm, input bit ok);
    n_tests++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain got idle=%0d left=%0d want 1 0",
               nm, ok, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ready, busy, vga_plot} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 100",
               {ready, busy, vga_plot});
    end
    n_tests++;
    if ({vga_x, vga_y, vga_colour} !== '0) begin
      n_fail++;
      $display("FAIL reset_pixel got %0d/%0d/%0d want 0/0/0",
               vga_x, vga_y, vga_colour);
    end
    check_clip("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int n, t;
    bit ok;
    mon_cnt = 0;
    send(32'h0A05_0003, 1'b1, n);
    wait_idle(50, t, ok);
    check_done("single", ok);
    n_tests++;
    if (mon_cnt !== 1 || mon_first !== n + 1) begin
      n_fail++;
      $display("FAIL single_timing got beats=%0d at=%0d want 1 at %0d",
               mon_cnt, mon_first, n + 1);
    end
    n_tests++;
    if (t !== n + 2) begin
      n_fail++;
      $display("FAIL single_busy got idle at %0d want %0d", t, n + 2);
    end
    n_tests++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !==
        {1'b0, 8'd5, 7'd10, 3'd3}) begin
      n_fail++;
      $display("FAIL single_hold got p=%0d x=%0d y=%0d c=%0d want 0 5 10 3",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    check_clip("single");
  endtask

  task automatic test_span;
    int n, t;
    bit ok;
    mon_cnt = 0;
    send(32'h8514_0302, 1'b1, n);
    wait_idle(50, t, ok);
    check_done("span", ok);
    n_tests++;
    if (mon_cnt !== 4 || mon_first !== n + 1 || mon_last !== n + 4) begin
      n_fail++;
      $display("FAIL span_timing got %0d beats %0d..%0d want 4 %0d..%0d",
               mon_cnt, mon_first, mon_last, n + 1, n + 4);
    end
    n_tests++;
    if (t !== n + 5) begin
      n_fail++;
      $display("FAIL span_busy got idle at %0d want %0d", t, n + 5);
    end
    check_clip("span");
  endtask

  task automatic test_right_clip;
    int n, t;
    bit ok;
    mon_cnt = 0;
    send({1'b1, 7'd30, 8'd158, 8'd9, 8'd5}, 1'b1, n);
    wait_idle(50, t, ok);
    check_done("rclip", ok);
    n_tests++;
    if (mon_cnt !== 2 || t !== n + 3) begin
      n_fail++;
      $display("FAIL rclip_beats got %0d idle %0d want 2 idle %0d",
               mon_cnt, t, n + 3);
    end
    check_clip("rclip");
  endtask

  task automatic test_offscreen;
    logic [31:0] cmds [5];
    int want [5];
    int n, t;
    bit ok;
    cmds[0] = {1'b0, 7'd0,   8'd160, 8'd0, 8'd1};
    cmds[1] = {1'b0, 7'd120, 8'd0,   8'd0, 8'd2};
    cmds[2] = {1'b1, 7'd120, 8'd3,   8'd4, 8'd4};
    cmds[3] = {1'b1, 7'd0,   8'd255, 8'd2, 8'd6};
    cmds[4] = {1'b0, 7'd119, 8'd159, 8'd0, 8'd7};
    want = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      mon_cnt = 0;
      send(cmds[i], 1'b1, n);
      wait_idle(50, t, ok);
      check_done("offscreen", ok);
      n_tests++;
      if (mon_cnt !== want[i] || t !== n + 2) begin
        n_fail++;
        $display("FAIL offscreen%0d got beats=%0d idle=%0d want %0d %0d",
                 i, mon_cnt, t, want[i], n + 2);
      end
      check_clip("offscreen");
    end
  endtask

  task automatic test_back_to_back;
    bit rdy [5];
    int n0, t;
    bit ok;
    mon_cnt = 0;
    burst({1'b1, 7'd50, 8'd0, 8'd15, 8'd1}, rdy, n0);
    n_tests++;
    if ({rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]} !== 5'b11110) begin
      n_fail++;
      $display("FAIL b2b_ready got %b want 11110",
               {rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]});
    end
    wait_idle(100, t, ok);
    check_done("b2b", ok);
    n_tests++;
    if (mon_cnt !== 20 || mon_last - mon_first !== 19) begin
      n_fail++;
      $display("FAIL b2b_gapless got %0d beats over %0d cyc want 20 20",
               mon_cnt, mon_last - mon_first + 1);
    end
    check_clip("b2b");
  endtask

  task automatic test_full_pop;
    bit rdy [5];
    int n0, t;
    bit ok;
    mon_cnt = 0;
    burst({1'b1, 7'd40, 8'd10, 8'd3, 8'd2}, rdy, n0);
    n_tests++;
    if (rdy[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_ready got %0d want 0", rdy[4]);
    end
    wait_idle(100, t, ok);
    check_done("fullpop", ok);
    n_tests++;
    if (mon_cnt !== 8 || mon_last - mon_first !== 7) begin
      n_fail++;
      $display("FAIL fullpop_beats got %0d over %0d cyc want 8 8",
               mon_cnt, mon_last - mon_first + 1);
    end
  endtask

  task automatic test_reset_mid;
    int n, m;
    mon_cnt = 0;
    send({1'b1, 7'd10, 8'd10, 8'd40, 8'd6}, 1'b1, n);
    send({1'b0, 7'd20, 8'd20, 8'd0, 8'd1}, 1'b0, n);
    send({1'b0, 7'd21, 8'd21, 8'd0, 8'd2}, 1'b0, n);
    repeat (3) @(negedge clk);
    n_tests++;
    if (mon_cnt < 3 || vga_plot !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got beats=%0d plot=%0d want >=3 1",
               mon_cnt, vga_plot);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({vga_plot, ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL rstmid_flags got %b want 010",
               {vga_plot, ready, busy});
    end
    exp_q.delete();
    exp_clip = 0;
    check_clip("rstmid");
    @(negedge clk);
    rst = 1'b0;
    m   = mon_cnt;
    repeat (12) @(negedge clk);
    n_tests++;
    if (mon_cnt !== m || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_flush got beats=%0d busy=%0d want %0d 0",
               mon_cnt - m + m, busy, m);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_span;
    test_right_clip;
    test_offscreen;
    test_back_to_back;
    test_full_pop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
